txpld_sched: RTL and testbench

//   Per-TX-slot payload scheduler for the baseband TX buffers. At each payload

---
 rtl/txpld_sched.sv | 168 ++++++++++++++++
 tb/tb_txpld_sched.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txpld_sched.sv
// txpld_sched: per-TX-slot payload scheduler.
// Picks SCO, ACL or no payload at each payload start, runs the shared bit
// counter and buffer chip-selects, and handles ACL ARQ (SEQN, retransmit,
// buffer release).
module txpld_sched #(
   parameter int CNTW        = 13,
   parameter int SCO_BITS    = 240,
   parameter int ACL_MAXBITS = 2712
) (
   input  logic            clk_6M,
   input  logic            rstz,
   input  logic            tx_start_p,
   input  logic            sco_slot,
   input  logic            bit_en,
   input  logic            acl_rdy,
   input  logic [CNTW-1:0] acl_len,
   input  logic            rx_ack_p,
   input  logic            rx_arqn,
   output logic            lncacl_cs,
   output logic            lncsco_cs,
   output logic [CNTW-1:0] txlnctrl_bitcount,
   output logic [1:0]      tx_type,
   output logic            pld_busy,
   output logic            pld_done_p,
   output logic            txSEQN,
   output logic            acl_release_p
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SCO_TX   = 2'd1,
      ACL_TX   = 2'd2,
      ACK_WAIT = 2'd3
   } state_t;

   localparam logic [CNTW-1:0] SCO_LEN  = CNTW'(SCO_BITS);
   localparam logic [CNTW-1:0] ACL_MAX  = CNTW'(ACL_MAXBITS);
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);

   state_t          state, state_nxt, base_state;
   logic [CNTW-1:0] len, len_nxt;
   logic [CNTW-1:0] bitcount_nxt;
   logic [1:0]      tx_type_nxt;
   logic            acl_cs_nxt, sco_cs_nxt, busy_nxt, done_nxt;
   logic            seqn_nxt, release_nxt;
   logic            null_pend, null_pend_nxt;  // NULL slot: done pulse one cycle later
   logic            ret_ack, ret_ack_nxt;      // SCO slot interrupted an ACK wait

   // Register state and all outputs; reset clears everything, SEQN starts at 1.
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         state             <= IDLE;
         len               <= CNT_ZERO;
         txlnctrl_bitcount <= CNT_ZERO;
         tx_type           <= 2'b00;
         lncacl_cs         <= 1'b0;
         lncsco_cs         <= 1'b0;
         pld_busy          <= 1'b0;
         pld_done_p        <= 1'b0;
         txSEQN            <= 1'b1;
         acl_release_p     <= 1'b0;
         null_pend         <= 1'b0;
         ret_ack           <= 1'b0;
      end else begin
         state             <= state_nxt;
         len               <= len_nxt;
         txlnctrl_bitcount <= bitcount_nxt;
         tx_type           <= tx_type_nxt;
         lncacl_cs         <= acl_cs_nxt;
         lncsco_cs         <= sco_cs_nxt;
         pld_busy          <= busy_nxt;
         pld_done_p        <= done_nxt;
         txSEQN            <= seqn_nxt;
         acl_release_p     <= release_nxt;
         null_pend         <= null_pend_nxt;
         ret_ack           <= ret_ack_nxt;
      end
   end

   // Next-state and next-output logic: ACK handling first, then slot scheduling.
   always_comb begin
      state_nxt     = state;
      base_state    = state;
      len_nxt       = len;
      bitcount_nxt  = txlnctrl_bitcount;
      tx_type_nxt   = tx_type;
      acl_cs_nxt    = lncacl_cs;
      sco_cs_nxt    = lncsco_cs;
      busy_nxt      = pld_busy;
      done_nxt      = null_pend;
      null_pend_nxt = 1'b0;
      seqn_nxt      = txSEQN;
      release_nxt   = 1'b0;
      ret_ack_nxt   = ret_ack;
      case (state)
         IDLE, ACK_WAIT: begin
            // An ACK closes the outstanding packet before this cycle's slot is scheduled.
            if ((state == ACK_WAIT) && rx_ack_p && rx_arqn) begin
               release_nxt = 1'b1;
               seqn_nxt    = ~txSEQN;
               base_state  = IDLE;
            end else begin
               base_state  = state;
            end
            state_nxt = base_state;
            if (tx_start_p) begin
               if (sco_slot) begin
                  state_nxt    = SCO_TX;
                  len_nxt      = SCO_LEN;
                  tx_type_nxt  = 2'b10;
                  sco_cs_nxt   = 1'b1;
                  acl_cs_nxt   = 1'b0;
                  busy_nxt     = 1'b1;
                  bitcount_nxt = CNT_ZERO;
                  ret_ack_nxt  = (base_state == ACK_WAIT);
               end else if (acl_rdy && (acl_len != CNT_ZERO)) begin
                  // New packet from IDLE, or retransmission of the unacked one.
                  state_nxt    = ACL_TX;
                  len_nxt      = (acl_len > ACL_MAX) ? ACL_MAX : acl_len;
                  tx_type_nxt  = 2'b01;
                  acl_cs_nxt   = 1'b1;
                  sco_cs_nxt   = 1'b0;
                  busy_nxt     = 1'b1;
                  bitcount_nxt = CNT_ZERO;
                  ret_ack_nxt  = 1'b0;
               end else begin
                  tx_type_nxt   = 2'b00;
                  null_pend_nxt = 1'b1;
               end
            end else begin
               tx_type_nxt = tx_type;
            end
         end
         SCO_TX, ACL_TX: begin
            // Serve one bit per strobe; tx_start_p and rx_ack_p are ignored here.
            if (bit_en) begin
               if (txlnctrl_bitcount == (len - CNT_ONE)) begin
                  done_nxt     = 1'b1;
                  acl_cs_nxt   = 1'b0;
                  sco_cs_nxt   = 1'b0;
                  busy_nxt     = 1'b0;
                  bitcount_nxt = CNT_ZERO;
                  if (state == ACL_TX) begin
                     state_nxt = ACK_WAIT;
                  end else if (ret_ack) begin
                     state_nxt = ACK_WAIT;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  bitcount_nxt = txlnctrl_bitcount + CNT_ONE;
               end
            end else begin
               bitcount_nxt = txlnctrl_bitcount;
            end
         end
         default: begin
            state_nxt    = IDLE;
            acl_cs_nxt   = 1'b0;
            sco_cs_nxt   = 1'b0;
            busy_nxt     = 1'b0;
            bitcount_nxt = CNT_ZERO;
         end
      endcase
   end

endmodule

// File: tb/tb_txpld_sched.sv
// Self-checking bench for txpld_sched: directed scenarios plus randomized slots
// checked against a transaction-level model of the scheduler and ARQ.
module tb_txpld_sched;

   logic        clk_6M = 1'b0;
   logic        rstz = 1'b0;
   logic        tx_start_p = 1'b0;
   logic        sco_slot = 1'b0;
   logic        bit_en = 1'b0;
   logic        acl_rdy = 1'b0;
   logic [12:0] acl_len = 13'd0;
   logic        rx_ack_p = 1'b0;
   logic        rx_arqn = 1'b0;
   logic        lncacl_cs, lncsco_cs, pld_busy, pld_done_p, txSEQN, acl_release_p;
   logic [12:0] txlnctrl_bitcount;
   logic [1:0]  tx_type;

   txpld_sched dut (
      .clk_6M(clk_6M), .rstz(rstz), .tx_start_p(tx_start_p), .sco_slot(sco_slot),
      .bit_en(bit_en), .acl_rdy(acl_rdy), .acl_len(acl_len), .rx_ack_p(rx_ack_p),
      .rx_arqn(rx_arqn), .lncacl_cs(lncacl_cs), .lncsco_cs(lncsco_cs),
      .txlnctrl_bitcount(txlnctrl_bitcount), .tx_type(tx_type), .pld_busy(pld_busy),
      .pld_done_p(pld_done_p), .txSEQN(txSEQN), .acl_release_p(acl_release_p)
   );

   always #5 clk_6M = ~clk_6M;

   int n_chk = 0;
   int n_fail = 0;
   int phase = 0;

   // Reference model: ARQ state at transaction level
   logic m_seqn = 1'b1;   // SEQN the next ACL header must carry
   logic m_out  = 1'b0;   // an ACL packet has been sent and not yet ACKed

   // Observations of the last slot / ack
   logic [1:0] o_type;
   logic       o_sco, o_acl, o_seqn, o_both, o_after, o_rel, o_rel2, o_seqn_after;
   int         o_lat;
   int         bc_q[$];

   // One clock: advance to just after the edge, then drive the 1-in-6 bit strobe.
   task automatic cyc();
      @(posedge clk_6M);
      #1;
      phase  = (phase + 1) % 6;
      bit_en = (phase == 0);
   endtask

   // Issue a payload start and record what the DUT serves until pld_done_p.
   task automatic send_slot(input logic sco, input logic rdy, input logic [12:0] len);
      sco_slot   = sco;
      acl_rdy    = rdy;
      acl_len    = len;
      tx_start_p = 1'b1;
      cyc();
      tx_start_p = 1'b0;
      sco_slot   = 1'b0;
      o_type = tx_type;
      o_sco  = lncsco_cs;
      o_acl  = lncacl_cs;
      o_seqn = txSEQN;
      o_both = 1'b0;
      o_after = 1'b1;
      o_lat  = -1;
      bc_q.delete();
      for (int c = 1; c <= 20000; c++) begin
         if (lncacl_cs && lncsco_cs) o_both = 1'b1;
         if (pld_done_p) begin
            o_lat   = c;
            o_after = lncacl_cs | lncsco_cs | pld_busy | (txlnctrl_bitcount != 13'd0);
            break;
         end
         if (bit_en && pld_busy) bc_q.push_back(int'(txlnctrl_bitcount));
         cyc();
      end
      cyc();
   endtask

   // Deliver one ARQN pulse and record the release pulse and SEQN afterwards.
   task automatic send_ack(input logic arqn);
      rx_ack_p = 1'b1;
      rx_arqn  = arqn;
      cyc();
      rx_ack_p = 1'b0;
      rx_arqn  = 1'b0;
      o_rel        = acl_release_p;
      o_seqn_after = txSEQN;
      cyc();
      o_rel2 = acl_release_p;
   endtask

   function automatic logic seq_ok(input int l);
      if (bc_q.size() != l) return 1'b0;
      foreach (bc_q[i]) if (bc_q[i] != i) return 1'b0;
      return 1'b1;
   endfunction

   task automatic test_reset();
      rstz = 1'b0;
      repeat (3) cyc();
      n_chk++;
      if ({lncacl_cs, lncsco_cs, txlnctrl_bitcount, tx_type, pld_busy, pld_done_p, acl_release_p, txSEQN} !== {19'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_outputs got %b required %b",
                  {lncacl_cs, lncsco_cs, txlnctrl_bitcount, tx_type, pld_busy, pld_done_p, acl_release_p, txSEQN}, {19'd0, 1'b1});
      end
      @(negedge clk_6M);
      rstz = 1'b1;
      cyc();
      m_seqn = 1'b1;
      m_out  = 1'b0;
   endtask

   task automatic test_null();
      send_slot(1'b0, 1'b0, 13'd64);
      n_chk++;
      if ({o_type, o_acl, o_sco} !== 4'b0000) begin
         n_fail++;
         $display("FAIL null_type_cs got %b required %b", {o_type, o_acl, o_sco}, 4'b0000);
      end
      n_chk++;
      if (o_lat !== 2) begin
         n_fail++;
         $display("FAIL null_done_latency got %0d required %0d", o_lat, 2);
      end
      n_chk++;
      if (o_seqn !== 1'b1) begin
         n_fail++;
         $display("FAIL null_seqn got %0d required %0d", o_seqn, 1);
      end
   endtask

   task automatic test_sco();
      send_slot(1'b1, 1'b1, 13'd100);
      n_chk++;
      if ({o_type, o_acl, o_sco} !== 4'b1001) begin
         n_fail++;
         $display("FAIL sco_type_cs got %b required %b", {o_type, o_acl, o_sco}, 4'b1001);
      end
      n_chk++;
      if (seq_ok(240) !== 1'b1) begin
         n_fail++;
         $display("FAIL sco_bitcount_seq got %0d bits required %0d", bc_q.size(), 240);
      end
      n_chk++;
      if ({o_lat > 0, o_after, o_both} !== 3'b100) begin
         n_fail++;
         $display("FAIL sco_done_clear got lat=%0d after=%0d both=%0d required done with cs cleared", o_lat, o_after, o_both);
      end
   endtask

   task automatic test_acl_ack();
      send_slot(1'b0, 1'b1, 13'd64);
      m_out = 1'b1;
      n_chk++;
      if ({o_type, o_acl, o_sco, o_seqn} !== {2'b01, 1'b1, 1'b0, m_seqn}) begin
         n_fail++;
         $display("FAIL acl_type_cs_seqn got %b required %b", {o_type, o_acl, o_sco, o_seqn}, {2'b01, 1'b1, 1'b0, m_seqn});
      end
      n_chk++;
      if (seq_ok(64) !== 1'b1 || o_after !== 1'b0) begin
         n_fail++;
         $display("FAIL acl_bitcount_seq got %0d bits after=%0d required %0d bits", bc_q.size(), o_after, 64);
      end
      send_ack(1'b1);
      m_seqn = ~m_seqn;
      m_out  = 1'b0;
      n_chk++;
      if ({o_rel, o_rel2, o_seqn_after} !== {1'b1, 1'b0, m_seqn}) begin
         n_fail++;
         $display("FAIL acl_release got %b required %b", {o_rel, o_rel2, o_seqn_after}, {1'b1, 1'b0, m_seqn});
      end
   endtask

   task automatic test_nak_retx();
      logic [12:0] l;
      l = 13'($urandom_range(1, 120));
      send_slot(1'b0, 1'b1, l);
      m_out = 1'b1;
      send_slot(1'b0, 1'b1, l);
      n_chk++;
      if ({o_type, o_seqn, seq_ok(int'(l))} !== {2'b01, m_seqn, 1'b1}) begin
         n_fail++;
         $display("FAIL retx_noack got %b required %b", {o_type, o_seqn, seq_ok(int'(l))}, {2'b01, m_seqn, 1'b1});
      end
      send_ack(1'b0);
      n_chk++;
      if ({o_rel, o_seqn_after} !== {1'b0, m_seqn}) begin
         n_fail++;
         $display("FAIL nak_no_release got %b required %b", {o_rel, o_seqn_after}, {1'b0, m_seqn});
      end
      send_slot(1'b0, 1'b1, l);
      n_chk++;
      if ({o_type, o_seqn} !== {2'b01, m_seqn}) begin
         n_fail++;
         $display("FAIL retx_after_nak got %b required %b", {o_type, o_seqn}, {2'b01, m_seqn});
      end
      send_ack(1'b1);
      m_seqn = ~m_seqn;
      m_out  = 1'b0;
      n_chk++;
      if ({o_rel, o_seqn_after} !== {1'b1, m_seqn}) begin
         n_fail++;
         $display("FAIL retx_release got %b required %b", {o_rel, o_seqn_after}, {1'b1, m_seqn});
      end
   endtask

   task automatic test_sco_preempt();
      send_slot(1'b0, 1'b1, 13'd40);
      m_out = 1'b1;
      send_slot(1'b1, 1'b1, 13'd40);
      n_chk++;
      if ({o_type, o_sco, o_acl, seq_ok(240)} !== {2'b10, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL preempt_sco got %b required %b", {o_type, o_sco, o_acl, seq_ok(240)}, 5'b10101);
      end
      send_slot(1'b0, 1'b1, 13'd40);
      n_chk++;
      if ({o_type, o_seqn, seq_ok(40)} !== {2'b01, m_seqn, 1'b1}) begin
         n_fail++;
         $display("FAIL preempt_acl_resend got %b required %b", {o_type, o_seqn, seq_ok(40)}, {2'b01, m_seqn, 1'b1});
      end
      send_ack(1'b1);
      m_seqn = ~m_seqn;
      m_out  = 1'b0;
      n_chk++;
      if ({o_rel, o_seqn_after} !== {1'b1, m_seqn}) begin
         n_fail++;
         $display("FAIL preempt_release got %b required %b", {o_rel, o_seqn_after}, {1'b1, m_seqn});
      end
   endtask

   task automatic test_ack_with_start();
      logic r0, d0;
      logic [1:0] t0;
      send_slot(1'b0, 1'b1, 13'd20);
      m_out = 1'b1;
      rx_ack_p = 1'b1; rx_arqn = 1'b1; tx_start_p = 1'b1; acl_rdy = 1'b0; sco_slot = 1'b0;
      cyc();
      rx_ack_p = 1'b0; rx_arqn = 1'b0; tx_start_p = 1'b0;
      m_seqn = ~m_seqn;
      m_out  = 1'b0;
      r0 = acl_release_p;
      t0 = tx_type;
      n_chk++;
      if ({r0, txSEQN, t0, lncacl_cs, lncsco_cs} !== {1'b1, m_seqn, 2'b00, 2'b00}) begin
         n_fail++;
         $display("FAIL ack_start_same got %b required %b", {r0, txSEQN, t0, lncacl_cs, lncsco_cs}, {1'b1, m_seqn, 4'b0000});
      end
      cyc();
      d0 = pld_done_p;
      n_chk++;
      if (d0 !== 1'b1) begin
         n_fail++;
         $display("FAIL ack_start_null_done got %0d required %0d", d0, 1);
      end
      cyc();
      send_ack(1'b1);
      n_chk++;
      if ({o_rel, o_seqn_after} !== {1'b0, m_seqn}) begin
         n_fail++;
         $display("FAIL idle_ack_ignored got %b required %b", {o_rel, o_seqn_after}, {1'b0, m_seqn});
      end
   endtask

   task automatic test_ignore_mid_payload();
      logic bad_sco, bad_rel, done;
      bad_sco = 1'b0; bad_rel = 1'b0; done = 1'b0;
      acl_rdy = 1'b1; acl_len = 13'd30; tx_start_p = 1'b1;
      cyc();
      tx_start_p = 1'b0;
      bc_q.delete();
      for (int c = 1; c <= 2000; c++) begin
         if (lncsco_cs) bad_sco = 1'b1;
         if (acl_release_p) bad_rel = 1'b1;
         if (pld_done_p) begin done = 1'b1; break; end
         if (bit_en && pld_busy) bc_q.push_back(int'(txlnctrl_bitcount));
         tx_start_p = (c == 20);
         sco_slot   = (c == 20);
         rx_ack_p   = (c == 40);
         rx_arqn    = (c == 40);
         cyc();
      end
      tx_start_p = 1'b0; sco_slot = 1'b0; rx_ack_p = 1'b0; rx_arqn = 1'b0;
      m_out = 1'b1;
      n_chk++;
      if ({done, seq_ok(30), bad_sco, bad_rel, tx_type} !== {1'b1, 1'b1, 1'b0, 1'b0, 2'b01}) begin
         n_fail++;
         $display("FAIL ignore_mid_payload got %b required %b", {done, seq_ok(30), bad_sco, bad_rel, tx_type}, 6'b110001);
      end
      cyc();
      send_ack(1'b1);
      m_seqn = ~m_seqn;
      m_out  = 1'b0;
      n_chk++;
      if ({o_rel, o_seqn_after} !== {1'b1, m_seqn}) begin
         n_fail++;
         $display("FAIL ignore_then_release got %b required %b", {o_rel, o_seqn_after}, {1'b1, m_seqn});
      end
   endtask

   task automatic test_random();
      logic sco, rdy, exp_rel;
      logic [12:0] l;
      int e, el, k;
      for (int s = 0; s < 24; s++) begin
         sco = ($urandom_range(0, 3) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         l   = ($urandom_range(0, 4) == 0) ? 13'd0 : 13'($urandom_range(1, 150));
         e   = sco ? 2 : ((rdy && l != 13'd0) ? 1 : 0);
         el  = (e == 2) ? 240 : ((e == 1) ? int'(l) : 0);
         send_slot(sco, rdy, l);
         n_chk++;
         if ({o_type, o_acl, o_sco} !== {2'(e), e == 1, e == 2}) begin
            n_fail++;
            $display("FAIL rand_type_cs slot %0d got %b required %b", s, {o_type, o_acl, o_sco}, {2'(e), e == 1, e == 2});
         end
         n_chk++;
         if ({seq_ok(el), o_seqn, o_both, (e == 0) ? (o_lat == 2) : (o_lat > 1)} !== {1'b1, m_seqn, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rand_payload slot %0d got bits=%0d seqn=%0d both=%0d lat=%0d required bits=%0d seqn=%0d",
                     s, bc_q.size(), o_seqn, o_both, o_lat, el, m_seqn);
         end
         if (e == 1) m_out = 1'b1;
         k = $urandom_range(0, 2);
         if (k != 0) begin
            send_ack(k == 1);
            exp_rel = (k == 1) && m_out;
            if (exp_rel) begin
               m_seqn = ~m_seqn;
               m_out  = 1'b0;
            end
            n_chk++;
            if ({o_rel, o_seqn_after} !== {exp_rel, m_seqn}) begin
               n_fail++;
               $display("FAIL rand_ack slot %0d got %b required %b", s, {o_rel, o_seqn_after}, {exp_rel, m_seqn});
            end
         end
      end
      if (m_out) begin
         send_ack(1'b1);
         m_seqn = ~m_seqn;
         m_out  = 1'b0;
      end
   endtask

   task automatic test_clamp();
      send_slot(1'b0, 1'b1, 13'd4000);
      m_out = 1'b1;
      n_chk++;
      if ({o_type, seq_ok(2712)} !== {2'b01, 1'b1}) begin
         n_fail++;
         $display("FAIL clamp_len got %0d bits required %0d", bc_q.size(), 2712);
      end
      send_ack(1'b1);
      m_seqn = ~m_seqn;
      m_out  = 1'b0;
   endtask

   task automatic test_async_reset();
      logic hit;
      if (m_seqn) begin
         send_slot(1'b0, 1'b1, 13'd8);
         send_ack(1'b1);
         m_seqn = ~m_seqn;
      end
      hit = 1'b0;
      acl_rdy = 1'b1; acl_len = 13'd4000; tx_start_p = 1'b1;
      cyc();
      tx_start_p = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (txlnctrl_bitcount == 13'd100) begin hit = 1'b1; break; end
         cyc();
      end
      n_chk++;
      if ({hit, txSEQN, lncacl_cs} !== 3'b101) begin
         n_fail++;
         $display("FAIL prereset_state got %b required %b", {hit, txSEQN, lncacl_cs}, 3'b101);
      end
      #2;
      rstz = 1'b0;
      #1;
      n_chk++;
      if ({lncacl_cs, lncsco_cs, txlnctrl_bitcount, tx_type, pld_busy, pld_done_p, acl_release_p, txSEQN} !== {19'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL async_reset got %b required %b",
                  {lncacl_cs, lncsco_cs, txlnctrl_bitcount, tx_type, pld_busy, pld_done_p, acl_release_p, txSEQN}, {19'd0, 1'b1});
      end
      @(negedge clk_6M);
      rstz = 1'b1;
      m_seqn = 1'b1;
      m_out  = 1'b0;
      cyc();
      send_slot(1'b0, 1'b1, 13'd12);
      n_chk++;
      if ({o_type, o_seqn, seq_ok(12)} !== {2'b01, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL post_reset_acl got %b required %b", {o_type, o_seqn, seq_ok(12)}, 4'b0111);
      end
   endtask

   initial begin
      phase = int'($urandom_range(0, 5));
      test_reset();
      test_null();
      test_sco();
      test_acl_ack();
      test_nak_retx();
      test_sco_preempt();
      test_ack_with_start();
      test_ignore_mid_payload();
      test_random();
      test_clamp();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
